hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline.
- Tracks the destination tags of in-flight instructions in its own EX/MEM/WB tag pipeline.
- Decides and registers operand-forwarding selects for the instruction entering EX.
- Generates ID stalls for load-use hazards and multi-cycle EX operations (multiply/divide), and supports branch flush.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- MUL_LAT, 4, EX occupancy in cycles of a multi-cycle op (≥1; 1 = single-cycle)
- ZERO_REG_EN, 1, when 1 register 0 never matches (hardwired zero)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_rd  in  REG_ADDR_W  ID destination
- id_reg_write  in  1  ID instruction writes a register
- id_mem_read  in  1  ID instruction is a load
- id_multi  in  1  ID instruction is multi-cycle
- flush  in  1  kill ID and EX instructions (branch taken in EX)
- stall  out  1  hold PC and IF/ID; insert bubble
- forward_a, forward_b  out  2  ALU operand selects for the EX instruction: 00 regfile, 01 WB result, 10 MEM result
- ex_hold  out  1  EX occupied by multi-cycle op, EX/MEM must load a bubble

## Operation
- Tag = {valid, rd, reg_write, is_load}; stages ex_t, mem_t, wb_t.
- A tag matches source s when tag.valid, tag.reg_write, tag.rd == s, the source is used, and not (ZERO_REG_EN and s == 0).
- stall = load_use | busy.
  - load_use: ID valid, ex_t is a load, and ex_t matches rs or rt.
  - busy: busy_cnt != 0.
- Advance (stall = 0):
  - ex_t ← ID tag (valid = id_valid).
  - forward_a ← 10 if ex_t matches id_rs; else 01 if mem_t matches id_rs; else 00.
  - forward_b is computed the same way from id_rt.
  - A and B are decided independently; the newer producer (EX) wins.
- Load-use stall:
  - ex_t ← bubble; forward_a/b ← 00.
  - mem_t ← ex_t; wb_t ← mem_t.
- Busy stall:
  - ex_t, forward_a/b hold.
  - mem_t ← bubble; wb_t ← mem_t.
- Shift order every cycle: wb_t ← mem_t. Outside busy, mem_t ← ex_t.
- Multi-cycle counter:
  - When a valid id_multi instruction advances into EX, busy_cnt ← MUL_LAT−1.
  - Each cycle busy_cnt > 0, it decrements.
  - ex_hold = (busy_cnt != 0).
- flush:
  - ex_t ← bubble and busy_cnt ← 0; forward_a/b ← 00.
  - mem_t ← ex_t (the branch itself, or the in-flight multi-cycle op, completes).
  - The ID instruction is discarded.
  - stall is forced 0 in a flush cycle.
  - flush has priority over all other updates.
- Load in MEM matching an ID source is not a hazard. When ID advances, the load moves to WB and the select is 01.

## Timing
- stall and ex_hold are combinational from registered state plus ID inputs; they are valid in the same cycle.
- forward_a/b are registered: they apply during the cycle after the ID instruction advances, i.e. while it is in EX.
- Load-use costs exactly 1 bubble.
- A multi-cycle op stalls ID for MUL_LAT−1 cycles after it enters EX.
- Reset (asynchronous, any cycle, including mid-busy):
  - All tags invalid, busy_cnt = 0.
  - stall = 0, ex_hold = 0, forward_a = forward_b = 00.
- MUL_LAT = 1: busy never asserts.

## Structure
- Shared package holds:
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - The tag struct type.
  - The bubble tag constant.
- One sub-module, fwd_src_match: compares one source against ex_t/mem_t and returns the 2-bit select plus a load-hit flag. It is instantiated twice (rs, rt).
- busy_cnt width is $clog2(MUL_LAT)+1.

## Test plan
- add r3 advances into EX, then sub r5,r3,r3 in ID → forward_a = forward_b = 10 next cycle, stall = 0.
- add r3; nop; or r6,r3,r4 → forward_a = 01, forward_b = 00 (r4 not in flight).
- lw r2 then add r7,r2,r1 → stall = 1 for 1 cycle, ex_t bubble; next cycle forward_a = 01.
- Producer writes r0, consumer reads r0 with ZERO_REG_EN = 1 → forward 00, no stall.
- mult with MUL_LAT = 4 → stall and ex_hold high for 3 cycles, MEM receives 3 bubbles. Separately, flush on the 2nd busy cycle → busy_cnt = 0, stall = 0 that cycle.
- Assert reset while busy_cnt = 2 → all outputs 0 immediately, and after release the first instruction advances with no stall.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forward select codes, pipeline tag and match helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Tag rd field is sized for the widest register file in use; narrower addresses are zero-extended.
    localparam int TAG_RD_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                reg_write;
        logic                is_load;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '{valid: 1'b0, rd: '0, reg_write: 1'b0, is_load: 1'b0};

    function automatic logic tag_hits(input tag_t                t,
                                      input logic [TAG_RD_W-1:0] src,
                                      input logic                src_used,
                                      input logic                zero_en);
        return t.valid && t.reg_write && src_used && (t.rd == src)
               && !(zero_en && (src == '0));
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_src_match.sv
// Forward select for one source operand against the EX and MEM tags, plus an EX-load hit flag.
// Purely combinational; no flow control.
module fwd_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  src_used,
    input  tag_t                  ex_t,
    input  tag_t                  mem_t,
    output logic [1:0]            sel,
    output logic                  ex_load_hit
);

    logic [TAG_RD_W-1:0] src_ext;
    logic                zero_en;
    logic                ex_hit;
    logic                mem_hit;
    logic                unused_mem_load;

    assign src_ext = TAG_RD_W'(src);
    assign zero_en = (ZERO_REG_EN != 0);

    assign ex_hit  = tag_hits(ex_t,  src_ext, src_used, zero_en);
    assign mem_hit = tag_hits(mem_t, src_ext, src_used, zero_en);

    // The instruction in EX now sits in MEM when the consumer reaches EX, hence the MEM select.
    assign sel = ex_hit  ? FWD_MEM :
                 mem_hit ? FWD_WB  : FWD_RF;

    assign ex_load_hit = ex_hit && ex_t.is_load;

    // A load already in MEM has its data by the time the consumer needs it.
    assign unused_mem_load = mem_t.is_load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding control for a 5-stage pipeline: stall and ex_hold are combinational, forward selects registered (1 cycle).
// Back-pressures ID via stall on load-use (1 bubble) or multi-cycle EX (MUL_LAT-1 cycles); flush overrides everything.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LAT     = 4,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_multi,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  ex_hold
);

    localparam int               CNT_W    = $clog2(MUL_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

    tag_t             ex_t;
    tag_t             mem_t;
    tag_t             wb_t;
    tag_t             id_tag;
    logic [CNT_W-1:0] busy_cnt;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_hit_a;
    logic       load_hit_b;
    logic       load_use;
    logic       busy;
    logic       unused_wb;

    fwd_src_match #(
        .REG_ADDR_W  (REG_ADDR_W),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match_rs (
        .src         (id_rs),
        .src_used    (id_uses_rs),
        .ex_t        (ex_t),
        .mem_t       (mem_t),
        .sel         (sel_a),
        .ex_load_hit (load_hit_a)
    );

    fwd_src_match #(
        .REG_ADDR_W  (REG_ADDR_W),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_match_rt (
        .src         (id_rt),
        .src_used    (id_uses_rt),
        .ex_t        (ex_t),
        .mem_t       (mem_t),
        .sel         (sel_b),
        .ex_load_hit (load_hit_b)
    );

    always_comb begin
        id_tag           = BUBBLE_TAG;
        id_tag.valid     = id_valid;
        id_tag.rd        = TAG_RD_W'(id_rd);
        id_tag.reg_write = id_reg_write;
        id_tag.is_load   = id_mem_read;
    end

    assign load_use = id_valid && (load_hit_a || load_hit_b);
    assign busy     = (busy_cnt != '0);
    assign stall    = !flush && (load_use || busy);
    assign ex_hold  = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_t      <= BUBBLE_TAG;
            mem_t     <= BUBBLE_TAG;
            wb_t      <= BUBBLE_TAG;
            busy_cnt  <= '0;
            forward_a <= FWD_RF;
            forward_b <= FWD_RF;
        end else begin
            wb_t <= mem_t;
            if (flush) begin
                // The branch (or a multi-cycle op still in EX) retires; the ID instruction is dropped.
                mem_t     <= ex_t;
                ex_t      <= BUBBLE_TAG;
                busy_cnt  <= '0;
                forward_a <= FWD_RF;
                forward_b <= FWD_RF;
            end else if (busy) begin
                mem_t    <= BUBBLE_TAG;
                busy_cnt <= busy_cnt - CNT_W'(1);
            end else if (load_use) begin
                mem_t     <= ex_t;
                ex_t      <= BUBBLE_TAG;
                forward_a <= FWD_RF;
                forward_b <= FWD_RF;
            end else begin
                mem_t     <= ex_t;
                ex_t      <= id_tag;
                forward_a <= sel_a;
                forward_b <= sel_b;
                if (id_valid && id_multi) begin
                    busy_cnt <= CNT_INIT;
                end
            end
        end
    end

    // WB tag completes the in-flight picture but nothing downstream consumes it here.
    assign unused_wb = ^wb_t;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    localparam int RW = 5;
    localparam int ML = 4;
    localparam int ZE = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic          id_reg_write, id_mem_read, id_multi;
    logic          flush;
    logic          stall, ex_hold;
    logic [1:0]    forward_a, forward_b;

    int checks = 0;
    int failures = 0;

    hazard_forward_ctrl #(
        .REG_ADDR_W  (RW),
        .MUL_LAT     (ML),
        .ZERO_REG_EN (ZE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_multi     (id_multi),
        .flush        (flush),
        .stall        (stall),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .ex_hold      (ex_hold)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight instructions by stage (0 = EX, 1 = MEM, 2 = WB) and remaining busy cycles.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } minst_t;

    minst_t stage[3];
    int     busy_left;
    int     m_fa, m_fb;
    bit     obs_stall, obs_hold;

    function automatic minst_t empty_inst();
        minst_t e;
        e.v = 0; e.rd = 0; e.wr = 0; e.ld = 0;
        return e;
    endfunction

    function automatic bit writes(minst_t t, int s, bit used);
        return t.v && t.wr && used && (t.rd == s) && !(ZE != 0 && s == 0);
    endfunction

    // Youngest in-flight producer wins: in EX now -> MEM data next cycle (2), in MEM now -> WB data (1).
    function automatic int want_fwd(int s, bit used);
        for (int k = 0; k < 2; k++)
            if (writes(stage[k], s, used)) return 2 - k;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) stage[k] = empty_inst();
        busy_left = 0;
        m_fa = 0;
        m_fb = 0;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input int rd, input bit rw, input bit ld, input bit mul, input bit fl);
        bit lu, bz, exp_stall;
        int na, nb;
        minst_t nw;
        @(negedge clk);
        id_valid = v; id_rs = RW'(rs); id_rt = RW'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_rd = RW'(rd);
        id_reg_write = rw; id_mem_read = ld; id_multi = mul; flush = fl;
        #1;
        lu = v && stage[0].ld && (writes(stage[0], rs, urs) || writes(stage[0], rt, urt));
        bz = busy_left > 0;
        exp_stall = !fl && (lu || bz);
        obs_stall = stall;
        obs_hold  = ex_hold;
        chk("stall", {1'b0, stall}, {1'b0, exp_stall});
        chk("ex_hold", {1'b0, ex_hold}, {1'b0, bz});
        chk("forward_a", forward_a, 2'(m_fa));
        chk("forward_b", forward_b, 2'(m_fb));
        na = want_fwd(rs, urs);
        nb = want_fwd(rt, urt);
        @(posedge clk);
        if (fl) begin
            stage[2] = stage[1]; stage[1] = stage[0]; stage[0] = empty_inst();
            busy_left = 0; m_fa = 0; m_fb = 0;
        end else if (bz) begin
            stage[2] = stage[1]; stage[1] = empty_inst();
            busy_left--;
        end else if (lu) begin
            stage[2] = stage[1]; stage[1] = stage[0]; stage[0] = empty_inst();
            m_fa = 0; m_fb = 0;
        end else begin
            nw.v = v; nw.rd = rd; nw.wr = rw; nw.ld = ld;
            stage[2] = stage[1]; stage[1] = stage[0]; stage[0] = nw;
            m_fa = na; m_fb = nb;
            if (v && mul) busy_left = ML - 1;
        end
    endtask

    task automatic expect_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        #1;
        chk({tag, "_a"}, forward_a, a);
        chk({tag, "_b"}, forward_b, b);
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk({tag, "_stall"}, {1'b0, stall}, 2'b00);
        chk({tag, "_hold"}, {1'b0, ex_hold}, 2'b00);
        chk({tag, "_fa"}, forward_a, 2'b00);
        chk({tag, "_fb"}, forward_b, 2'b00);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0;
        id_mem_read = 0; id_multi = 0; flush = 0;
        model_reset();
        #12;
        do_reset("reset");

        // add r3 ; sub r5,r3,r3 -> both operands from MEM
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        step(1, 3, 3, 1, 1, 5, 1, 0, 0, 0);
        chk("sub_stall", {1'b0, obs_stall}, 2'b00);
        expect_fwd("ex_fwd", 2'b10, 2'b10);

        // add r3 ; nop ; or r6,r3,r4
        nop(); nop(); nop();
        step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
        nop();
        step(1, 3, 4, 1, 1, 6, 1, 0, 0, 0);
        expect_fwd("mem_fwd", 2'b01, 2'b00);

        // lw r2 ; add r7,r2,r1 -> one bubble then WB forward
        nop(); nop(); nop();
        step(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        step(1, 2, 1, 1, 1, 7, 1, 0, 0, 0);
        chk("lu_stall", {1'b0, obs_stall}, 2'b01);
        expect_fwd("lu_bubble", 2'b00, 2'b00);
        step(1, 2, 1, 1, 1, 7, 1, 0, 0, 0);
        chk("lu_release", {1'b0, obs_stall}, 2'b00);
        expect_fwd("lu_fwd", 2'b01, 2'b00);

        // load to r0 then read r0: hardwired zero never matches
        nop(); nop(); nop();
        step(1, 1, 0, 1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
        chk("r0_stall", {1'b0, obs_stall}, 2'b00);
        expect_fwd("r0_fwd", 2'b00, 2'b00);

        // mult: 3 busy cycles
        nop(); nop(); nop();
        step(1, 1, 2, 1, 1, 8, 1, 0, 1, 0);
        for (int k = 0; k < ML - 1; k++) begin
            step(1, 9, 10, 1, 1, 11, 1, 0, 0, 0);
            chk("mul_stall", {1'b0, obs_stall}, 2'b01);
            chk("mul_hold", {1'b0, obs_hold}, 2'b01);
        end
        step(1, 9, 10, 1, 1, 11, 1, 0, 0, 0);
        chk("mul_done", {1'b0, obs_stall}, 2'b00);

        // mult with flush on the 2nd busy cycle
        nop(); nop(); nop();
        step(1, 1, 2, 1, 1, 8, 1, 0, 1, 0);
        step(1, 9, 10, 1, 1, 11, 1, 0, 0, 0);
        step(1, 9, 10, 1, 1, 11, 1, 0, 0, 1);
        chk("flush_stall", {1'b0, obs_stall}, 2'b00);
        nop();
        chk("flush_hold", {1'b0, obs_hold}, 2'b00);

        // reset asserted mid-busy
        nop(); nop();
        step(1, 1, 2, 1, 1, 8, 1, 0, 1, 0);
        nop();
        do_reset("midbusy");
        step(1, 1, 2, 1, 1, 12, 1, 0, 0, 0);
        chk("post_reset_stall", {1'b0, obs_stall}, 2'b00);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 8,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
